// File: rtl/sha_uart_ctrl.sv
// rtl/sha_uart_ctrl.sv - UART byte-stream sequencer for the SHA-256 compression core
// Frames: header byte, 64 block bytes, then ACK or 32-byte digest back to TX.
module sha_uart_ctrl #(
  parameter int          RX_TIMEOUT = 1000000,
  parameter logic [7:0]  ACK_BYTE   = 8'h06,
  parameter logic [7:0]  NAK_BYTE   = 8'h15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_rx_valid,
  input  logic [7:0]   i_rx_byte,
  output logic         o_tx_valid,
  output logic [7:0]   o_tx_byte,
  input  logic         i_tx_ready,
  output logic         o_blk_start,
  output logic         o_blk_first,
  output logic [511:0] o_blk_data,
  input  logic         i_core_done,
  input  logic [255:0] i_digest,
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, BUSY, SEND, ACK, NAK, DONE
  } state_t;

  localparam int TW = $clog2(RX_TIMEOUT + 1);

  state_t         state;
  logic [5:0]     cnt;
  logic [4:0]     idx;
  logic [TW-1:0]  timer;
  logic           first_flag;
  logic           last_flag;
  logic [255:0]   digest;

  assign o_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      timer       <= '0;
      first_flag  <= 1'b0;
      last_flag   <= 1'b0;
      digest      <= '0;
      o_tx_valid  <= 1'b0;
      o_tx_byte   <= '0;
      o_blk_start <= 1'b0;
      o_blk_first <= 1'b0;
      o_blk_data  <= '0;
      o_done      <= 1'b0;
    end else begin
      o_blk_start <= 1'b0;
      o_done      <= 1'b0;
      case (state)
        IDLE: begin
          if (i_rx_valid) begin
            first_flag <= i_rx_byte[0];
            last_flag  <= i_rx_byte[1];
            if (i_rx_byte[7:2] == 6'd0) begin
              state <= LOAD;
              cnt   <= '0;
              timer <= '0;
            end else begin
              state      <= NAK;
              o_tx_valid <= 1'b1;
              o_tx_byte  <= NAK_BYTE;
            end
          end
        end

        LOAD: begin
          // A byte arriving in the same cycle as the timeout still counts.
          if (i_rx_valid) begin
            o_blk_data <= {o_blk_data[503:0], i_rx_byte};
            cnt        <= cnt + 6'd1;
            timer      <= '0;
            if (cnt == 6'd63) begin
              state       <= START;
              o_blk_start <= 1'b1;
              o_blk_first <= first_flag;
            end
          end else if (timer == TW'(RX_TIMEOUT - 1)) begin
            state      <= NAK;
            o_tx_valid <= 1'b1;
            o_tx_byte  <= NAK_BYTE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        START: begin
          state       <= BUSY;
          o_blk_first <= 1'b0;
        end

        BUSY: begin
          if (i_core_done) begin
            digest     <= i_digest;
            o_tx_valid <= 1'b1;
            if (last_flag) begin
              state     <= SEND;
              idx       <= '0;
              o_tx_byte <= i_digest[255:248];
            end else begin
              state     <= ACK;
              o_tx_byte <= ACK_BYTE;
            end
          end
        end

        SEND: begin
          // The digest register shifts left so the next byte is always at [247:240].
          if (i_tx_ready) begin
            if (idx == 5'd31) begin
              state      <= DONE;
              o_tx_valid <= 1'b0;
              o_tx_byte  <= '0;
              o_done     <= 1'b1;
            end else begin
              idx       <= idx + 5'd1;
              o_tx_byte <= digest[247:240];
              digest    <= {digest[247:0], 8'h00};
            end
          end
        end

        ACK, NAK: begin
          if (i_tx_ready) begin
            state      <= IDLE;
            o_tx_valid <= 1'b0;
            o_tx_byte  <= '0;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_uart_ctrl.sv
// tb/tb_sha_uart_ctrl.sv - scoreboard bench for sha_uart_ctrl
// Stimulus pushes expected tx bytes and block starts; a negedge monitor pops and compares.
module tb_sha_uart_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_valid;
  logic [7:0]   rx_byte;
  logic         tx_valid;
  logic [7:0]   tx_byte;
  logic         tx_ready;
  logic         blk_start;
  logic         blk_first;
  logic [511:0] blk_data;
  logic         core_done;
  logic [255:0] digest;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  sha_uart_ctrl #(.RX_TIMEOUT(100), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
    .clk(clk), .rst(rst),
    .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
    .o_tx_valid(tx_valid), .o_tx_byte(tx_byte), .i_tx_ready(tx_ready),
    .o_blk_start(blk_start), .o_blk_first(blk_first), .o_blk_data(blk_data),
    .i_core_done(core_done), .i_digest(digest),
    .o_busy(busy), .o_done(done)
  );

  typedef struct packed { logic [7:0] b; logic last; } tx_exp_t;
  typedef struct packed { logic first; logic [511:0] data; } blk_exp_t;

  tx_exp_t  exp_tx[$];
  blk_exp_t exp_blk[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic prev_final = 1'b0;

  localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] DIG_MID = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;

  logic [511:0] blk_abc;
  logic [511:0] blk_two1;
  logic [511:0] blk_two2;
  logic [447:0] msg56;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic this_final;
    tx_exp_t  te;
    blk_exp_t be;
    this_final = 1'b0;
    if (rst) begin
      prev_final <= 1'b0;
    end else begin
      if (done || prev_final) check("done_after_last", 512'(done), 512'(prev_final));
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          check("unexpected_tx", 512'(tx_byte), 512'h1ff);
        end else begin
          te = exp_tx.pop_front();
          check("tx_byte", 512'(tx_byte), 512'(te.b));
          this_final = te.last;
        end
      end
      if (blk_start) begin
        if (exp_blk.size() == 0) begin
          check("unexpected_start", 512'(1), 512'(0));
        end else begin
          be = exp_blk.pop_front();
          check("blk_first", 512'(blk_first), 512'(be.first));
          check("blk_data", blk_data, be.data);
        end
      end
      prev_final <= this_final;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic send_block(input logic [7:0] hdr, input logic [511:0] blk);
    exp_blk.push_back({hdr[0], blk});
    send_byte(hdr);
    for (int i = 0; i < 64; i++) send_byte(blk[511-8*i -: 8]);
    check("start_latency", 512'(blk_start), 512'(1));
  endtask

  task automatic core_reply(input logic [255:0] d, input logic last);
    repeat (5) @(posedge clk);
    #1;
    if (last) begin
      for (int i = 0; i < 32; i++) exp_tx.push_back({d[255-8*i -: 8], i == 31});
    end else begin
      exp_tx.push_back({8'h06, 1'b0});
    end
    core_done = 1'b1;
    digest    = d;
    @(posedge clk); #1;
    core_done = 1'b0;
    digest    = '0;
    check("tx_latency", 512'(tx_valid), 512'(1));
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || exp_tx.size() != 0) && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 512'(busy || exp_tx.size() != 0), 512'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_outputs", {tx_valid, tx_byte, blk_start, blk_first, busy, done}, 512'(0));
    check("reset_blk_data", blk_data, 512'(0));
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int bad_stall;
    logic [7:0] hold;

    msg56    = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    blk_abc  = {24'h616263, 8'h80, 416'h0, 64'h18};
    blk_two1 = {msg56, 8'h80, 56'h0};
    blk_two2 = {448'h0, 64'h1c0};

    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_ready = 1'b1;
    core_done = 1'b0; digest = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {tx_valid, tx_byte, blk_start, blk_first, busy, done}, 512'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // single-block "abc" frame
    send_block(8'h03, blk_abc);
    core_reply(DIG_ABC, 1'b1);
    wait_idle("idle_abc");

    // two-block frame pair: ACK after the first, digest after the second
    send_block(8'h01, blk_two1);
    core_reply(DIG_MID, 1'b0);
    wait_idle("idle_two1");
    send_block(8'h02, blk_two2);
    core_reply(DIG_TWO, 1'b1);
    wait_idle("idle_two2");

    // bad header
    exp_tx.push_back({8'h15, 1'b0});
    send_byte(8'h05);
    check("bad_hdr_nak", {tx_valid, tx_byte}, {1'b1, 8'h15});
    wait_idle("idle_badhdr");

    // timeout after 10 data bytes
    exp_tx.push_back({8'h15, 1'b0});
    send_byte(8'h01);
    for (int i = 0; i < 10; i++) send_byte(8'(i + 1));
    k = 0;
    while (!tx_valid && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check("timeout_cycles", 512'(k), 512'(100));
    wait_idle("idle_timeout");
    send_block(8'h03, blk_abc);
    core_reply(DIG_ABC, 1'b1);
    wait_idle("idle_after_timeout");

    // tx backpressure during SEND
    send_block(8'h03, blk_abc);
    core_reply(DIG_ABC, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    tx_ready  = 1'b0;
    hold      = tx_byte;
    bad_stall = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!tx_valid || tx_byte !== hold) bad_stall++;
    end
    check("stall_stable", 512'(bad_stall), 512'(0));
    tx_ready = 1'b1;
    wait_idle("idle_stall");

    // reset while BUSY, then a late core_done
    send_block(8'h03, blk_abc);
    @(posedge clk); #1;
    pulse_reset();
    core_done = 1'b1; digest = DIG_ABC;
    @(posedge clk); #1;
    core_done = 1'b0; digest = '0;
    repeat (5) @(posedge clk);
    #1;
    check("late_done_ignored", {tx_valid, busy}, 512'(0));

    // reset while SEND
    send_block(8'h03, blk_abc);
    tx_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    core_done = 1'b1; digest = DIG_ABC;
    @(posedge clk); #1;
    core_done = 1'b0; digest = '0;
    check("send_first_byte", {tx_valid, tx_byte}, {1'b1, 8'hba});
    pulse_reset();
    tx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_after_send_rst", {tx_valid, busy}, 512'(0));

    check("tx_queue_empty", 512'(exp_tx.size()), 512'(0));
    check("blk_queue_empty", 512'(exp_blk.size()), 512'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
